// File: rtl/load_store_stage.sv
// Memory-access stage: RV32I loads/stores over a req/ack word RAM, registered writeback bundle.
// Latency: 1 cycle for pass-through/exceptions, 2 cycles + RAM wait cycles for memory ops.
// Backpressure: in_ready low while a RAM transaction is outstanding; upstream holds in_*.
module load_store_stage #(
   parameter int MEM_AW = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_is_load,
   input  logic              in_is_store,
   input  logic [2:0]        in_funct3,
   input  logic [31:0]       in_alu_y,
   input  logic [31:0]       in_rs2_value,
   input  logic [4:0]        in_rd_addr,
   input  logic              in_rd_en,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              wb_valid,
   output logic              wb_rd_en,
   output logic [4:0]        wb_rd_addr,
   output logic [31:0]       wb_rd_value,
   output logic [1:0]        wb_exc
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   logic [2:0]  l_funct3;
   logic [1:0]  l_off;
   logic        l_is_load;
   logic        l_rd_en;
   logic [4:0]  l_rd_addr;

   logic        is_mem;
   logic        illegal;
   logic        misaligned;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;

   assign in_ready = (state == IDLE);
   assign is_mem   = in_is_load | in_is_store;

   // Legality and alignment of the incoming access; a store flag wins if both are set.
   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      if (in_is_store) begin
         illegal = in_funct3[2] | (in_funct3[1:0] == 2'b11);
      end else begin
         case (in_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
            default:                                illegal = 1'b1;
         endcase
      end
      if (in_funct3[1:0] == 2'b01) misaligned = in_alu_y[0];
      if (in_funct3[1:0] == 2'b10) misaligned = (in_alu_y[1:0] != 2'b00);
   end

   // Lane-replicated store data and byte enables; loads never write any lane.
   always_comb begin
      st_wdata = in_rs2_value;
      st_wstrb = 4'b0000;
      case (in_funct3[1:0])
         2'b00: begin
            st_wdata = {4{in_rs2_value[7:0]}};
            st_wstrb = 4'b0001 << in_alu_y[1:0];
         end
         2'b01: begin
            st_wdata = {2{in_rs2_value[15:0]}};
            st_wstrb = in_alu_y[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = in_rs2_value;
            st_wstrb = 4'b1111;
         end
      endcase
      if (!in_is_store) st_wstrb = 4'b0000;
   end

   // Lane select and sign/zero extension of the returned word using the latched offset.
   always_comb begin
      case (l_off)
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = l_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (l_funct3)
         3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_value = {24'd0, ld_byte};
         3'b101:  ld_value = {16'd0, ld_half};
         default: ld_value = mem_rdata;
      endcase
   end

   // Stage FSM: accept in IDLE, hold the RAM request in BUSY until ack, register writeback.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wstrb   <= '0;
         wb_valid    <= 1'b0;
         wb_rd_en    <= 1'b0;
         wb_rd_addr  <= '0;
         wb_rd_value <= '0;
         wb_exc      <= 2'b00;
         l_funct3    <= '0;
         l_off       <= '0;
         l_is_load   <= 1'b0;
         l_rd_en     <= 1'b0;
         l_rd_addr   <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (!is_mem) begin
                     wb_valid    <= 1'b1;
                     wb_rd_en    <= in_rd_en;
                     wb_rd_addr  <= in_rd_addr;
                     wb_rd_value <= in_alu_y;
                     wb_exc      <= 2'b00;
                  end else if (illegal || misaligned) begin
                     wb_valid    <= 1'b1;
                     wb_rd_en    <= 1'b0;
                     wb_rd_addr  <= in_rd_addr;
                     wb_rd_value <= '0;
                     wb_exc      <= illegal ? 2'b10 : 2'b01;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= in_is_store;
                     mem_addr  <= in_alu_y[MEM_AW+1:2];
                     mem_wdata <= st_wdata;
                     mem_wstrb <= st_wstrb;
                     l_funct3  <= in_funct3;
                     l_off     <= in_alu_y[1:0];
                     l_is_load <= ~in_is_store;
                     l_rd_en   <= in_rd_en;
                     l_rd_addr <= in_rd_addr;
                     state     <= BUSY;
                  end
               end
            end
            default: begin
               if (mem_ack) begin
                  mem_req     <= 1'b0;
                  mem_we      <= 1'b0;
                  state       <= IDLE;
                  wb_valid    <= 1'b1;
                  wb_rd_en    <= l_is_load & l_rd_en;
                  wb_rd_addr  <= l_rd_addr;
                  wb_rd_value <= l_is_load ? ld_value : 32'd0;
                  wb_exc      <= 2'b00;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_stage.sv
// Directed bench for load_store_stage: table of single operations plus hand-written
// sequences for back-to-back issue and reset while a transaction is outstanding.
module tb_load_store_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_is_load = 1'b0;
   logic        in_is_store = 1'b0;
   logic [2:0]  in_funct3 = '0;
   logic [31:0] in_alu_y = '0;
   logic [31:0] in_rs2_value = '0;
   logic [4:0]  in_rd_addr = '0;
   logic        in_rd_en = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        wb_valid;
   logic        wb_rd_en;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_value;
   logic [1:0]  wb_exc;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] ram [16];

   always #5 clk = ~clk;

   load_store_stage #(.MEM_AW(12)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_funct3(in_funct3), .in_alu_y(in_alu_y), .in_rs2_value(in_rs2_value),
      .in_rd_addr(in_rd_addr), .in_rd_en(in_rd_en),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr),
      .wb_rd_value(wb_rd_value), .wb_exc(wb_exc)
   );

   typedef struct packed {
      bit        ld;
      bit        st;
      bit [2:0]  f3;
      bit [31:0] a;
      bit [31:0] rs2;
      bit [4:0]  rd;
      bit        rd_en;
      bit [3:0]  wt;
      bit        e_mem;
      bit [11:0] e_addr;
      bit [3:0]  e_wstrb;
      bit [31:0] e_wdata;
      bit [31:0] e_val;
      bit        e_rd_en;
      bit [1:0]  e_exc;
   } vec_t;

   vec_t vecs [21];

   function automatic vec_t mk(bit ld, bit st, bit [2:0] f3, bit [31:0] a, bit [31:0] rs2,
                               bit [4:0] rd, bit rd_en, bit [3:0] wt, bit e_mem,
                               bit [11:0] e_addr, bit [3:0] e_wstrb, bit [31:0] e_wdata,
                               bit [31:0] e_val, bit e_rd_en, bit [1:0] e_exc);
      vec_t v;
      v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.rs2 = rs2; v.rd = rd; v.rd_en = rd_en;
      v.wt = wt; v.e_mem = e_mem; v.e_addr = e_addr; v.e_wstrb = e_wstrb;
      v.e_wdata = e_wdata; v.e_val = e_val; v.e_rd_en = e_rd_en; v.e_exc = e_exc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit ld, input bit st, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] rs2, input bit [4:0] rd, input bit rd_en);
      in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
      in_alu_y = a; in_rs2_value = rs2; in_rd_addr = rd; in_rd_en = rd_en;
   endtask

   // Called at a negedge while mem_req is high: answer from the bench RAM, merging stores.
   task automatic ram_ack();
      mem_ack = 1'b1;
      mem_rdata = ram[mem_addr[3:0]];
      if (mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) ram[mem_addr[3:0]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [11:0] snap_addr;
      @(negedge clk);
      check($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
      drive(v.ld, v.st, v.f3, v.a, v.rs2, v.rd, v.rd_en);
      @(negedge clk);
      in_valid = 1'b0;
      if (v.e_mem) begin
         check($sformatf("v%0d mem_req", idx), {31'd0, mem_req}, 32'd1);
         check($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.st});
         check($sformatf("v%0d mem_addr", idx), {20'd0, mem_addr}, {20'd0, v.e_addr});
         check($sformatf("v%0d mem_wstrb", idx), {28'd0, mem_wstrb}, {28'd0, v.e_wstrb});
         if (v.st) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
         check($sformatf("v%0d early wb_valid", idx), {31'd0, wb_valid}, 32'd0);
         snap_addr = mem_addr;
         for (int w = 0; w < int'(v.wt); w++) begin
            check($sformatf("v%0d wait in_ready", idx), {31'd0, in_ready}, 32'd0);
            // Garbage presented while busy must be ignored.
            drive(1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'd0, 5'd31, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d wait mem_req", idx), {31'd0, mem_req}, 32'd1);
            check($sformatf("v%0d wait mem_addr", idx), {20'd0, mem_addr}, {20'd0, snap_addr});
            check($sformatf("v%0d wait wb_valid", idx), {31'd0, wb_valid}, 32'd0);
         end
         ram_ack();
         @(negedge clk);
         mem_ack = 1'b0;
         check($sformatf("v%0d post mem_req", idx), {31'd0, mem_req}, 32'd0);
         check($sformatf("v%0d post in_ready", idx), {31'd0, in_ready}, 32'd1);
      end else begin
         check($sformatf("v%0d no mem_req", idx), {31'd0, mem_req}, 32'd0);
      end
      check($sformatf("v%0d wb_valid", idx), {31'd0, wb_valid}, 32'd1);
      check($sformatf("v%0d wb_rd_en", idx), {31'd0, wb_rd_en}, {31'd0, v.e_rd_en});
      check($sformatf("v%0d wb_rd_addr", idx), {27'd0, wb_rd_addr}, {27'd0, v.rd});
      check($sformatf("v%0d wb_exc", idx), {30'd0, wb_exc}, {30'd0, v.e_exc});
      if (v.e_rd_en) check($sformatf("v%0d wb_rd_value", idx), wb_rd_value, v.e_val);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 32'd0;
      ram[2] = 32'h8899AABB;

      //            ld st f3      addr          rs2           rd  en wt mem addr  strb   wdata         value         ren exc
      vecs[0]  = mk(1, 0, 3'b010, 32'h8,        32'h0,        4,  1, 0, 1, 12'd2, 4'h0, 32'h0,        32'h8899AABB, 1, 2'b00);
      vecs[1]  = mk(1, 0, 3'b000, 32'h9,        32'h0,        1,  1, 0, 1, 12'd2, 4'h0, 32'h0,        32'hFFFFFFAA, 1, 2'b00);
      vecs[2]  = mk(1, 0, 3'b100, 32'hB,        32'h0,        2,  1, 0, 1, 12'd2, 4'h0, 32'h0,        32'h00000088, 1, 2'b00);
      vecs[3]  = mk(1, 0, 3'b001, 32'hA,        32'h0,        3,  1, 0, 1, 12'd2, 4'h0, 32'h0,        32'hFFFF8899, 1, 2'b00);
      vecs[4]  = mk(1, 0, 3'b101, 32'h8,        32'h0,        5,  1, 0, 1, 12'd2, 4'h0, 32'h0,        32'h0000AABB, 1, 2'b00);
      vecs[5]  = mk(0, 1, 3'b000, 32'h6,        32'h123456EF, 6,  1, 0, 1, 12'd1, 4'h4, 32'hEFEFEFEF, 32'h0,        0, 2'b00);
      vecs[6]  = mk(0, 1, 3'b001, 32'h6,        32'h123456EF, 6,  1, 0, 1, 12'd1, 4'hC, 32'h56EF56EF, 32'h0,        0, 2'b00);
      vecs[7]  = mk(1, 0, 3'b010, 32'h4,        32'h0,        10, 1, 0, 1, 12'd1, 4'h0, 32'h0,        32'h56EF0000, 1, 2'b00);
      vecs[8]  = mk(0, 1, 3'b010, 32'h4,        32'hDEADBEEF, 11, 1, 1, 1, 12'd1, 4'hF, 32'hDEADBEEF, 32'h0,        0, 2'b00);
      vecs[9]  = mk(1, 0, 3'b010, 32'h4,        32'h0,        8,  1, 3, 1, 12'd1, 4'h0, 32'h0,        32'hDEADBEEF, 1, 2'b00);
      vecs[10] = mk(1, 0, 3'b000, 32'h7,        32'h0,        12, 1, 0, 1, 12'd1, 4'h0, 32'h0,        32'hFFFFFFDE, 1, 2'b00);
      vecs[11] = mk(1, 0, 3'b100, 32'h6,        32'h0,        13, 1, 2, 1, 12'd1, 4'h0, 32'h0,        32'h000000AD, 1, 2'b00);
      vecs[12] = mk(1, 0, 3'b010, 32'h2,        32'h0,        14, 1, 0, 0, 12'd0, 4'h0, 32'h0,        32'h0,        0, 2'b01);
      vecs[13] = mk(1, 0, 3'b011, 32'h8,        32'h0,        15, 1, 0, 0, 12'd0, 4'h0, 32'h0,        32'h0,        0, 2'b10);
      vecs[14] = mk(0, 1, 3'b100, 32'h0,        32'h0,        16, 1, 0, 0, 12'd0, 4'h0, 32'h0,        32'h0,        0, 2'b10);
      vecs[15] = mk(1, 0, 3'b110, 32'h1,        32'h0,        17, 1, 0, 0, 12'd0, 4'h0, 32'h0,        32'h0,        0, 2'b10);
      vecs[16] = mk(1, 0, 3'b001, 32'h9,        32'h0,        18, 1, 0, 0, 12'd0, 4'h0, 32'h0,        32'h0,        0, 2'b01);
      vecs[17] = mk(0, 0, 3'b000, 32'h55,       32'h0,        7,  1, 0, 0, 12'd0, 4'h0, 32'h0,        32'h00000055, 1, 2'b00);
      vecs[18] = mk(0, 0, 3'b010, 32'h12345678, 32'h0,        0,  0, 0, 0, 12'd0, 4'h0, 32'h0,        32'h0,        0, 2'b00);
      vecs[19] = mk(0, 1, 3'b001, 32'h5,        32'hAAAA5555, 19, 1, 0, 0, 12'd0, 4'h0, 32'h0,        32'h0,        0, 2'b01);
      vecs[20] = mk(1, 0, 3'b010, 32'h4008,     32'h0,        20, 1, 0, 1, 12'd2, 4'h0, 32'h0,        32'h8899AABB, 1, 2'b00);

      // Reset state
      #12;
      check("rst mem_req", {31'd0, mem_req}, 32'd0);
      check("rst wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst wb_rd_en", {31'd0, wb_rd_en}, 32'd0);
      check("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
      check("rst wb_rd_value", wb_rd_value, 32'd0);
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 21; i++) run_vec(i, vecs[i]);

      // Back-to-back: pass-through, then LW accepted the very next cycle, then pass-through again
      @(negedge clk);
      drive(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd7, 1'b1);
      @(negedge clk);
      check("b2b pass wb_valid", {31'd0, wb_valid}, 32'd1);
      check("b2b pass value", wb_rd_value, 32'h55);
      check("b2b pass rd", {27'd0, wb_rd_addr}, 32'd7);
      check("b2b in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd9, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b lw wb_valid low", {31'd0, wb_valid}, 32'd0);
      check("b2b lw mem_req", {31'd0, mem_req}, 32'd1);
      ram_ack();
      @(negedge clk);
      mem_ack = 1'b0;
      check("b2b lw wb_valid", {31'd0, wb_valid}, 32'd1);
      check("b2b lw value", wb_rd_value, 32'h8899AABB);
      check("b2b lw rd", {27'd0, wb_rd_addr}, 32'd9);
      drive(1'b0, 1'b0, 3'b000, 32'hCAFE0001, 32'h0, 5'd3, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b second pass wb_valid", {31'd0, wb_valid}, 32'd1);
      check("b2b second pass value", wb_rd_value, 32'hCAFE0001);
      @(negedge clk);
      check("b2b idle wb_valid", {31'd0, wb_valid}, 32'd0);

      // Reset asserted while a load is outstanding
      drive(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 5'd5, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check("arst busy mem_req", {31'd0, mem_req}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("arst mem_req", {31'd0, mem_req}, 32'd0);
      check("arst wb_valid", {31'd0, wb_valid}, 32'd0);
      check("arst in_ready", {31'd0, in_ready}, 32'd1);
      check("arst mem_addr", {20'd0, mem_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post-rst in_ready", {31'd0, in_ready}, 32'd1);
      check("post-rst mem_req", {31'd0, mem_req}, 32'd0);
      check("post-rst wb_valid", {31'd0, wb_valid}, 32'd0);
      run_vec(99, vecs[17]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
